// File: rtl/rgb888_to_fp_feeder_pkg.sv
// Shared definitions for the float HSV path: fp32 field geometry, feeder FSM
// encoding and common fp32 constants.
package rgb888_to_fp_feeder_pkg;

  localparam int unsigned FP32_BIAS   = 127;
  localparam int unsigned FP32_MANT_W = 23;
  localparam int unsigned FP32_EXP_W  = 8;
  localparam int unsigned FP32_W      = 32;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] CONV_R = 2'd1;
  localparam logic [STATE_W-1:0] CONV_G = 2'd2;
  localparam logic [STATE_W-1:0] CONV_B = 2'd3;

  // Constants used by the downstream HSV stages.
  localparam logic [FP32_W-1:0] FP32_60  = 32'h4270_0000;
  localparam logic [FP32_W-1:0] FP32_120 = 32'h42F0_0000;
  localparam logic [FP32_W-1:0] FP32_240 = 32'h4370_0000;
  localparam logic [FP32_W-1:0] FP32_360 = 32'h43B4_0000;
  localparam logic [FP32_W-1:0] FP32_255 = 32'h437F_0000;

endpackage

// File: rtl/rgb888_to_fp_feeder_uint_to_fp32.sv
// Exact unsigned-integer to fp32 conversion for inputs of at most 24 bits;
// a priority encoder finds the leading one, so no rounding is ever needed.
module rgb888_to_fp_feeder_uint_to_fp32
  import rgb888_to_fp_feeder_pkg::*;
#(
  parameter int unsigned CH_WIDTH = 8
) (
  input  logic [CH_WIDTH-1:0] in,
  output logic [31:0]         out
);

  logic [4:0]             msb;
  logic [4:0]             shamt;
  logic [23:0]            ext;
  logic [FP32_MANT_W-1:0] mant;
  logic [FP32_EXP_W-1:0]  expo;

  // Leading-one position; the highest set bit wins.
  always_comb begin
    msb = 5'd0;
    for (int i = 0; i < CH_WIDTH; i++) begin
      if (in[i]) begin
        msb = 5'(i);
      end
    end
  end

  // Left-align the leading one at bit 23 and drop it as the implicit bit.
  always_comb begin
    ext   = 24'(in);
    shamt = 5'(FP32_MANT_W) - msb;
    mant  = 23'(ext << shamt);
    expo  = 8'(FP32_BIAS) + 8'(msb);
    if (in == '0) begin
      out = 32'h0000_0000;
    end else begin
      out = {1'b0, expo, mant};
    end
  end

endmodule

// File: rtl/rgb888_to_fp_feeder.sv
// Converts packed unsigned RGB pixels to three fp32 values, sharing one
// converter across the channels over three clocks per pixel.
module rgb888_to_fp_feeder
  import rgb888_to_fp_feeder_pkg::*;
#(
  parameter int unsigned CH_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3*CH_WIDTH-1:0]   pixel_in,
  input  logic                    data_val_in,
  output logic                    in_ready,
  output logic [31:0]             r,
  output logic [31:0]             g,
  output logic [31:0]             b,
  output logic                    data_val_out
);

  localparam int unsigned PIX_W = 3 * CH_WIDTH;

  logic [STATE_W-1:0]  state;
  logic [STATE_W-1:0]  state_next;
  logic                accept;
  logic [PIX_W-1:0]    pix_q;
  logic [CH_WIDTH-1:0] ch_sel;
  logic [31:0]         ch_fp;
  logic [31:0]         staging_r;
  logic [31:0]         staging_g;

  // A new pixel may land on the CONV_B edge, giving 3-clock throughput.
  assign in_ready = (state == IDLE) || (state == CONV_B);
  assign accept   = data_val_in && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CONV_R;
      CONV_R:  state_next = CONV_G;
      CONV_G:  state_next = CONV_B;
      CONV_B:  state_next = accept ? CONV_R : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Channel mux into the single shared converter.
  always_comb begin
    ch_sel = pix_q[CH_WIDTH-1:0];
    case (state)
      CONV_R:  ch_sel = pix_q[PIX_W-1 -: CH_WIDTH];
      CONV_G:  ch_sel = pix_q[2*CH_WIDTH-1 -: CH_WIDTH];
      default: ch_sel = pix_q[CH_WIDTH-1:0];
    endcase
  end

  rgb888_to_fp_feeder_uint_to_fp32 #(
    .CH_WIDTH (CH_WIDTH)
  ) u_uint_to_fp32 (
    .in  (ch_sel),
    .out (ch_fp)
  );

  // R and G are staged so all three outputs update together on CONV_B.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q        <= '0;
      staging_r    <= 32'h0;
      staging_g    <= 32'h0;
      r            <= 32'h0;
      g            <= 32'h0;
      b            <= 32'h0;
      data_val_out <= 1'b0;
    end else begin
      data_val_out <= 1'b0;
      if (accept) begin
        pix_q <= pixel_in;
      end
      case (state)
        CONV_R: staging_r <= ch_fp;
        CONV_G: staging_g <= ch_fp;
        CONV_B: begin
          r            <= staging_r;
          g            <= staging_g;
          b            <= ch_fp;
          data_val_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb888_to_fp_feeder.sv
// Directed bench for rgb888_to_fp_feeder: reset, single pixel, back-to-back,
// backpressure, mid-flight reset and a full 0..255 channel sweep.
module tb_rgb888_to_fp_feeder;

  logic        clk;
  logic        rst;
  logic [23:0] pixel_in;
  logic        data_val_in;
  logic        in_ready;
  logic [31:0] r;
  logic [31:0] g;
  logic [31:0] b;
  logic        data_val_out;

  int tests;
  int errors;

  rgb888_to_fp_feeder #(.CH_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_in     (pixel_in),
    .data_val_in  (data_val_in),
    .in_ready     (in_ready),
    .r            (r),
    .g            (g),
    .b            (b),
    .data_val_out (data_val_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference fp32 derived from the double-precision encoding of n.
  function automatic logic [31:0] to_fp32(input int n);
    logic [63:0] d;
    if (n == 0) return 32'h0;
    d = $realtobits(real'(n));
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Accept one pixel from IDLE, then measure latency and check the result.
  task automatic run_pixel(input string tag, input logic [23:0] pix,
                           input logic [31:0] er, input logic [31:0] eg,
                           input logic [31:0] eb);
    int lat;
    pixel_in    = pix;
    data_val_in = 1'b1;
    tick();
    data_val_in = 1'b0;
    lat = 0;
    while (!data_val_out && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " r"}, r, er);
    check({tag, " g"}, g, eg);
    check({tag, " b"}, b, eb);
  endtask

  initial begin
    int pulses;
    tests       = 0;
    errors      = 0;
    rst         = 1'b1;
    pixel_in    = 24'h0;
    data_val_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset then idle
    check("rst r", r, 32'h0);
    check("rst g", g, 32'h0);
    check("rst b", b, 32'h0);
    check("rst dvo", 32'(data_val_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("idle in_ready", 32'(in_ready), 32'd1);
      check("idle dvo", 32'(data_val_out), 32'd0);
      tick();
    end

    // Single pixel with explicit per-cycle checks
    pixel_in    = 24'hFF_00_80;
    data_val_in = 1'b1;
    tick();
    data_val_in = 1'b0;
    check("single busy in_ready", 32'(in_ready), 32'd0);
    check("single E0 dvo", 32'(data_val_out), 32'd0);
    tick();
    check("single E1 dvo", 32'(data_val_out), 32'd0);
    tick();
    check("single E2 dvo", 32'(data_val_out), 32'd0);
    check("single CONV_B in_ready", 32'(in_ready), 32'd1);
    tick();
    check("single E3 dvo", 32'(data_val_out), 32'd1);
    check("single r", r, 32'h437F_0000);
    check("single g", g, 32'h0000_0000);
    check("single b", b, 32'h4300_0000);
    tick();
    check("single E4 dvo", 32'(data_val_out), 32'd0);
    check("single hold r", r, 32'h437F_0000);
    check("single hold b", b, 32'h4300_0000);

    // Back-to-back with data_val_in held high
    pixel_in    = 24'h01_02_03;
    data_val_in = 1'b1;
    tick();
    pixel_in = 24'h3C_78_F0;
    tick();
    tick();
    check("b2b CONV_B in_ready", 32'(in_ready), 32'd1);
    tick();
    data_val_in = 1'b0;
    check("b2b first dvo", 32'(data_val_out), 32'd1);
    check("b2b first r", r, 32'h3F80_0000);
    check("b2b first g", g, 32'h4000_0000);
    check("b2b first b", b, 32'h4040_0000);
    check("b2b second busy", 32'(in_ready), 32'd0);
    tick();
    check("b2b gap dvo", 32'(data_val_out), 32'd0);
    check("b2b gap r", r, 32'h3F80_0000);
    tick();
    check("b2b gap2 dvo", 32'(data_val_out), 32'd0);
    tick();
    check("b2b second dvo", 32'(data_val_out), 32'd1);
    check("b2b second r", r, 32'h4270_0000);
    check("b2b second g", g, 32'h42F0_0000);
    check("b2b second b", b, 32'h4370_0000);
    tick();

    // Backpressure: a different pixel offered during CONV_R/CONV_G is dropped
    pixel_in    = 24'h10_20_30;
    data_val_in = 1'b1;
    tick();
    pixel_in = 24'hAA_BB_CC;
    tick();
    tick();
    data_val_in = 1'b0;
    tick();
    check("bp dvo", 32'(data_val_out), 32'd1);
    check("bp r", r, 32'h4180_0000);
    check("bp g", g, 32'h4200_0000);
    check("bp b", b, 32'h4240_0000);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (data_val_out) pulses++;
    end
    check("bp extra pulses", 32'(pulses), 32'd0);

    // Reset while in CONV_G aborts the pixel
    pixel_in    = 24'h55_66_77;
    data_val_in = 1'b1;
    tick();
    data_val_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort r", r, 32'h0);
    check("abort g", g, 32'h0);
    check("abort b", b, 32'h0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (data_val_out) pulses++;
      tick();
    end
    check("abort pulses", 32'(pulses), 32'd0);
    run_pixel("post-abort", 24'h01_80_FF, 32'h3F80_0000, 32'h4300_0000, 32'h437F_0000);
    tick();

    // Exhaustive channel sweep
    for (int n = 0; n < 256; n++) begin
      run_pixel($sformatf("sweep %0d", n), {8'(n), 8'(n), 8'(n)},
                to_fp32(n), to_fp32(n), to_fp32(n));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/rgb888_to_fp_feeder.md
Name: rgb888_to_fp_feeder

Overview:
Front-end stage of the float HSV path. Accepts packed unsigned 8-bit-per-channel RGB pixels and converts each channel to IEEE-754 single precision. Presents r/g/b floats plus a one-cycle data_val_out pulse, which drive the r, g, b and data_val_in inputs of the float RGB-to-HSV stage directly. A single shared integer-to-float converter is time-multiplexed over the three channels by an FSM.

Parameters:
CH_WIDTH, 8, unsigned bits per channel; legal range 1..24, so every value is exactly representable in fp32.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
pixel_in  input  3*CH_WIDTH  packed pixel: [3W-1:2W]=R, [2W-1:W]=G, [W-1:0]=B.
data_val_in  input  1  pixel_in is valid this cycle.
in_ready  output  1  block can accept a pixel this cycle (combinational from state).
r  output  32  fp32 red, registered.
g  output  32  fp32 green, registered.
b  output  32  fp32 blue, registered.
data_val_out  output  1  r/g/b hold a new converted pixel; one-cycle pulse.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; r=g=b=32'h0; data_val_out=0; staging registers cleared. Reset applies in any state and aborts an in-flight pixel with no output pulse.
- States: IDLE, CONV_R, CONV_G, CONV_B.
- in_ready = (state==IDLE) || (state==CONV_B).
- Accept: data_val_in && in_ready at an edge latches pixel_in into the input register, and the state goes to CONV_R. data_val_in while in_ready=0 is ignored; the pixel is not queued, and upstream must hold or retry it.
- CONV_R edge: staging_r <= cvt(R) -> CONV_G.
- CONV_G edge: staging_g <= cvt(G) -> CONV_B.
- CONV_B edge: r <= staging_r, g <= staging_g, b <= cvt(B), all in the same edge. data_val_out <= 1.
  - Next state is CONV_R if a new pixel is accepted on this edge, else IDLE.
- data_val_out is 0 on every other edge. r/g/b hold their values until the next CONV_B edge and never change while data_val_out=1.
- Latency: accept edge E0 -> outputs and data_val_out visible after edge E3 (3 clocks).
- Throughput: 1 pixel per 3 clocks back-to-back, because the next accept can coincide with the CONV_B edge.
- cvt(x), exact with no rounding:
  - x=0 -> 32'h0000_0000.
  - Otherwise let p = index of the MSB set in x. sign=0; exp=127+p; mantissa = (x << (23-p))[22:0], implicit 1 dropped.
  - Examples: 1 -> 3F80_0000, 128 -> 4300_0000, 255 -> 437F_0000.
- Leading-one detection is a priority encoder over CH_WIDTH bits. There is no multi-cycle normalisation loop.

Decomposition:
- Shared package:
  - FP32_BIAS = 127 and FP32_MANT_W = 23.
  - State encoding: IDLE=2'd0, CONV_R=2'd1, CONV_G=2'd2, CONV_B=2'd3.
  - The fp constants 60.0, 120.0, 240.0, 360.0 and 255.0 used by the HSV stages, so all stages share one definition.
- One natural sub-module: uint_to_fp32.
  - Combinational, parameter CH_WIDTH, in [CH_WIDTH-1:0], out [31:0].
  - Instantiated once and fed by a channel mux selected by state.

Test Plan:
- Reset then idle: after rst pulse, r=g=b=0, data_val_out=0, in_ready=1 for all idle cycles.
- Single pixel: pixel_in=24'hFF_00_80 with data_val_in at E0 -> after E3, r=437F_0000, g=0000_0000, b=4300_0000, data_val_out high exactly one cycle. After that, outputs hold.
- Back-to-back:
  - Stream 24'h01_02_03 then 24'h3C_78_F0 with data_val_in held high.
  - Second pixel accepted on the first pixel's CONV_B edge. Pulses 3 cycles apart.
  - First result: 3F80_0000 / 4000_0000 / 4040_0000. Second result: 4270_0000 / 42F0_0000 / 4370_0000.
  - First result stable during its pulse.
- Backpressure: data_val_in asserted in CONV_R/CONV_G with a different pixel -> ignored. Output matches only the accepted pixel, and no extra pulse occurs.
- Reset mid-operation: assert rst in CONV_G -> next cycle state IDLE, r/g/b=0, no data_val_out pulse for the aborted pixel. The next pixel converts correctly.
- Exhaustive channel sweep: R=G=B=n for n=0..255 -> each channel equals $shortrealtobits(real'(n)), and the latency is always 3.
